// File: rtl/debug_ctrl_v2.sv
// debug_ctrl_v2: UART debug controller that loads, runs, steps and dumps the MIPS core
module debug_ctrl_v2 #(
   parameter int INST_WIDTH = 32,
   parameter int ADDR_WIDTH = 6,
   parameter int NS         = 4,
   parameter int NC         = 48,
   parameter int CYC_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rx_done,
   input  logic [7:0]            rx_data,
   input  logic                  tx_done,
   output logic                  tx_start,
   output logic [7:0]            tx_data,
   input  logic                  halt_in,
   input  logic [31:0]           pc,
   input  logic [NS*32-1:0]      snap_bus,
   input  logic [31:0]           coll_word,
   output logic                  coll_next,
   output logic                  coll_restart,
   output logic                  mips_clk_en,
   output logic                  mips_reset,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [INST_WIDTH-1:0] imem_data,
   output logic                  debug_mode,
   output logic [2:0]            state_out
);
   localparam int IB = INST_WIDTH / 8;
   localparam int L  = 4 * (1 + NS + 1 + NC);
   localparam int IW = $clog2(L + 1);
   localparam int BW = $clog2(IB + 5);
   localparam logic [IW-1:0] LAST = IW'(L - 1);
   localparam logic [IW-1:0] NSW  = IW'(NS);
   localparam logic [IW-1:0] CB   = IW'(4 * (NS + 2));

   typedef enum logic [2:0] {
      IDLE = 3'd0, PROG = 3'd1, WAIT = 3'd2, STEP = 3'd3, RUN = 3'd4, SEND = 3'd5, BPLOAD = 3'd6
   } state_t;

   state_t               state;
   logic [CYC_WIDTH-1:0] cyc;
   logic [31:0]          bp_addr;
   logic                 bp_en;
   logic [IW-1:0]        idx;
   logic [BW-1:0]        bi;
   logic                 stepping;
   logic                 cause_halt;
   logic                 busy;
   logic                 bp_hit;
   logic [IW-1:0]        wi;
   logic [IW-1:0]        snap_i;
   logic [31:0]          cur_word;

   assign bp_hit      = bp_en && pc == bp_addr;
   assign mips_clk_en = (state == RUN && !halt_in && !bp_hit) || (state == STEP && stepping);
   assign mips_reset  = state == IDLE || state == PROG || state == WAIT;
   assign debug_mode  = state == PROG || state == SEND;
   assign state_out   = state;

   // Dump byte selection: word index picks pc, snapshot, cycle count or the live collector word
   always_comb begin
      wi       = idx >> 2;
      snap_i   = (wi >= IW'(1) && wi <= NSW) ? wi - IW'(1) : '0;
      cur_word = (wi == '0) ? pc :
                 (wi <= NSW) ? 32'(snap_bus >> {snap_i, 5'd0}) :
                 (wi == NSW + IW'(1)) ? 32'(cyc) : coll_word;
      tx_data  = (state == SEND) ? 8'(cur_word >> {idx[1:0], 3'd0}) : 8'd0;
      coll_next = state == SEND && busy && tx_done && idx[1:0] == 2'd3 && idx >= CB;
   end

   // Main controller FSM
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         imem_addr    <= '0;
         imem_data    <= '0;
         imem_we      <= 1'b0;
         tx_start     <= 1'b0;
         coll_restart <= 1'b0;
         cyc          <= '0;
         bp_addr      <= '0;
         bp_en        <= 1'b0;
         idx          <= '0;
         bi           <= '0;
         stepping     <= 1'b0;
         cause_halt   <= 1'b0;
         busy         <= 1'b0;
      end else begin
         imem_we      <= 1'b0;
         tx_start     <= 1'b0;
         coll_restart <= 1'b0;
         case (state)
            IDLE: if (rx_done && rx_data == 8'h01) begin
               state     <= PROG;
               imem_addr <= '0;
               bi        <= '0;
            end
            PROG: if (imem_we) begin
               if (&imem_data[INST_WIDTH-1 -: 6] || &imem_addr) state <= WAIT;
               if (!(&imem_addr)) imem_addr <= imem_addr + ADDR_WIDTH'(1);
            end else if (rx_done) begin
               imem_data <= INST_WIDTH'({rx_data, imem_data} >> 8);
               imem_we   <= bi == BW'(IB - 1);
               bi        <= (bi == BW'(IB - 1)) ? '0 : bi + BW'(1);
            end
            WAIT: if (rx_done && (rx_data == 8'h02 || rx_data == 8'h08)) begin
               state <= RUN;
               bp_en <= rx_data == 8'h08;
               cyc   <= '0;
            end else if (rx_done && rx_data == 8'h03) begin
               state    <= STEP;
               stepping <= 1'b0;
               cyc      <= '0;
            end else if (rx_done && rx_data == 8'h07) begin
               state <= BPLOAD;
               bi    <= '0;
            end else if (rx_done && rx_data == 8'h05) state <= IDLE;
            BPLOAD: if (rx_done) begin
               bp_addr <= {rx_data, bp_addr[31:8]};
               bi      <= (bi == BW'(3)) ? '0 : bi + BW'(1);
               if (bi == BW'(3)) state <= WAIT;
            end
            RUN: if (halt_in || bp_hit) begin
               state      <= SEND;
               cause_halt <= halt_in;
               if (!halt_in) bp_en <= 1'b0;
               idx        <= '0;
               tx_start   <= 1'b1;
               busy       <= 1'b1;
            end else if (!(&cyc)) cyc <= cyc + CYC_WIDTH'(1);
            STEP: if (stepping) begin
               stepping   <= 1'b0;
               if (!(&cyc)) cyc <= cyc + CYC_WIDTH'(1);
               state      <= SEND;
               cause_halt <= 1'b0;
               idx        <= '0;
               tx_start   <= 1'b1;
               busy       <= 1'b1;
            end else if (rx_done && rx_data == 8'h06) stepping <= 1'b1;
            else if (rx_done && rx_data == 8'h05) state <= IDLE;
            SEND: if (busy && tx_done) begin
               if (idx == LAST) begin
                  busy         <= 1'b0;
                  idx          <= '0;
                  coll_restart <= 1'b1;
                  state        <= cause_halt ? WAIT : STEP;
               end else begin
                  idx      <= idx + IW'(1);
                  tx_start <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_debug_ctrl_v2.sv
// tb_debug_ctrl_v2: directed table and sequence bench for the UART debug controller
module tb_debug_ctrl_v2;
   localparam int NS = 4, NC = 48, L = 4 * (1 + NS + 1 + NC);

   typedef struct {
      logic [7:0] b;
      logic [2:0] st;
      logic       mr;
      logic       dm;
   } vec_t;

   logic clk = 1'b0, reset = 1'b1, rx_done = 1'b0, tx_done = 1'b0, halt_in = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic [31:0] pc = 32'h0;
   logic [31:0] coll_word;
   logic [NS*32-1:0] snap_bus;
   logic [31:0] snapv [NS];
   logic tx_start, coll_next, coll_restart, mips_clk_en, mips_reset, imem_we, debug_mode;
   logic [7:0] tx_data;
   logic [5:0] imem_addr;
   logic [31:0] imem_data;
   logic [2:0] state_out;
   logic b_tx_start, b_coll_next, b_coll_restart, b_clk_en, b_mips_reset, b_imem_we, b_debug_mode;
   logic [7:0] b_tx_data;
   logic [1:0] b_imem_addr;
   logic [31:0] b_imem_data;
   logic [2:0] b_state;

   int total = 0, passed = 0;
   int nwe, nrestart, b_nwe, en_cnt, cidx;
   logic [31:0] log_addr [8], log_data [8];
   logic [1:0] b_addr [8];
   vec_t tbl [16];

   always #5 clk = ~clk;

   function automatic logic [31:0] colval(input int i);
      return 32'hC0000000 | (i << 16) | (i * 7 + 1);
   endfunction

   assign coll_word = colval(cidx);

   always_comb for (int i = 0; i < NS; i++) snap_bus[32*i +: 32] = snapv[i];

   debug_ctrl_v2 dut (
      .clk(clk), .reset(reset), .rx_done(rx_done), .rx_data(rx_data), .tx_done(tx_done),
      .tx_start(tx_start), .tx_data(tx_data), .halt_in(halt_in), .pc(pc), .snap_bus(snap_bus),
      .coll_word(coll_word), .coll_next(coll_next), .coll_restart(coll_restart),
      .mips_clk_en(mips_clk_en), .mips_reset(mips_reset), .imem_we(imem_we),
      .imem_addr(imem_addr), .imem_data(imem_data), .debug_mode(debug_mode), .state_out(state_out)
   );

   debug_ctrl_v2 #(.ADDR_WIDTH(2)) dut_small (
      .clk(clk), .reset(reset), .rx_done(rx_done), .rx_data(rx_data), .tx_done(1'b0),
      .tx_start(b_tx_start), .tx_data(b_tx_data), .halt_in(1'b0), .pc(32'h0), .snap_bus('0),
      .coll_word(32'h0), .coll_next(b_coll_next), .coll_restart(b_coll_restart),
      .mips_clk_en(b_clk_en), .mips_reset(b_mips_reset), .imem_we(b_imem_we),
      .imem_addr(b_imem_addr), .imem_data(b_imem_data), .debug_mode(b_debug_mode), .state_out(b_state)
   );

   // Registered-output monitors: write log and restart count
   always @(negedge clk) begin
      if (reset) begin
         nwe = 0;
         nrestart = 0;
         b_nwe = 0;
      end else begin
         if (imem_we) begin
            if (nwe < 8) begin
               log_addr[nwe] = 32'(imem_addr);
               log_data[nwe] = imem_data;
            end
            nwe++;
         end
         if (coll_restart) nrestart++;
         if (b_imem_we) begin
            if (b_nwe < 8) b_addr[b_nwe] = b_imem_addr;
            b_nwe++;
         end
      end
   end

   // Collector model and enabled-cycle counter, evaluated where the core sees them
   always @(posedge clk) begin
      if (reset) begin
         en_cnt <= 0;
         cidx <= 0;
      end else begin
         if (mips_clk_en) en_cnt <= en_cnt + 1;
         if (coll_restart) cidx <= 0;
         else if (coll_next) cidx <= cidx + 1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [7:0] exp_byte(input int k, input logic [31:0] pcv, input logic [31:0] cycv);
      int w;
      logic [31:0] v;
      w = k / 4;
      if (w == 0) v = pcv;
      else if (w <= NS) v = snapv[w-1];
      else if (w == NS + 1) v = cycv;
      else v = colval(w - NS - 2);
      return v[8*(k%4) +: 8];
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      rx_done = 1'b0;
      tx_done = 1'b0;
      halt_in = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data = b;
      rx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic prog_instr(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
   endtask

   task automatic pulse_cmd(input logic [7:0] b);
      rx_data = b;
      rx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
   endtask

   task automatic wait_tx(output logic ok);
      int n = 0;
      while (!tx_start && n < 50) begin
         @(negedge clk);
         n++;
      end
      ok = tx_start;
   endtask

   task automatic stream(input string tag, input logic [31:0] pcv, input logic [31:0] cycv, input logic [2:0] end_state);
      int err = 0, nn = 0, r0;
      logic [7:0] b;
      logic [31:0] cyc_got = 32'h0;
      logic ok = 1'b1;
      r0 = nrestart;
      for (int k = 0; k < L && ok; k++) begin
         wait_tx(ok);
         if (!ok) check({tag, " tx_start timeout"}, tx_start, 1);
         else begin
            if (k == 0) check({tag, " debug_mode in dump"}, debug_mode, 1);
            b = tx_data;
            if (b !== exp_byte(k, pcv, cycv) || mips_clk_en) err++;
            if (k >= 4 * (NS + 1) && k < 4 * (NS + 2)) cyc_got[8*(k-4*(NS+1)) +: 8] = b;
            repeat (2) @(negedge clk);
            if (tx_data !== b || tx_start) err++;
            tx_done = 1'b1;
            #1 if (coll_next) nn++;
            @(negedge clk);
            tx_done = 1'b0;
         end
      end
      repeat (3) @(negedge clk);
      check({tag, " stream bytes"}, err, 0);
      check({tag, " cycle field"}, cyc_got, cycv);
      check({tag, " coll_next count"}, nn, NC);
      check({tag, " coll_restart count"}, nrestart - r0, 1);
      check({tag, " end state"}, state_out, end_state);
   endtask

   initial begin
      logic ok, bad;
      int e0;
      for (int i = 0; i < NS; i++) snapv[i] = 32'h5A000000 + 32'(i * 32'h00111111);
      tbl[0]  = '{8'h02, 3'd0, 1'b1, 1'b0};
      tbl[1]  = '{8'h01, 3'd1, 1'b1, 1'b1};
      tbl[2]  = '{8'h00, 3'd1, 1'b1, 1'b1};
      tbl[3]  = '{8'h00, 3'd1, 1'b1, 1'b1};
      tbl[4]  = '{8'h00, 3'd1, 1'b1, 1'b1};
      tbl[5]  = '{8'hFC, 3'd2, 1'b1, 1'b0};
      tbl[6]  = '{8'h06, 3'd2, 1'b1, 1'b0};
      tbl[7]  = '{8'h04, 3'd2, 1'b1, 1'b0};
      tbl[8]  = '{8'h07, 3'd6, 1'b0, 1'b0};
      tbl[9]  = '{8'h10, 3'd6, 1'b0, 1'b0};
      tbl[10] = '{8'h00, 3'd6, 1'b0, 1'b0};
      tbl[11] = '{8'h00, 3'd6, 1'b0, 1'b0};
      tbl[12] = '{8'h00, 3'd2, 1'b1, 1'b0};
      tbl[13] = '{8'h03, 3'd3, 1'b0, 1'b0};
      tbl[14] = '{8'h05, 3'd0, 1'b1, 1'b0};
      tbl[15] = '{8'h01, 3'd1, 1'b1, 1'b1};

      do_reset();
      check("reset state", state_out, 0);
      check("reset mips_reset", mips_reset, 1);
      check("reset outs", {tx_start, mips_clk_en, debug_mode, imem_we, coll_restart, coll_next}, 0);
      check("reset addr/data", {imem_addr, tx_data}, 0);

      for (int i = 0; i < 16; i++) begin
         send_byte(tbl[i].b);
         check($sformatf("vec%0d state", i), state_out, tbl[i].st);
         check($sformatf("vec%0d mips_reset", i), mips_reset, tbl[i].mr);
         check($sformatf("vec%0d debug_mode", i), debug_mode, tbl[i].dm);
      end

      do_reset();
      send_byte(8'h01);
      prog_instr(32'h11223344);
      prog_instr(32'h55667788);
      prog_instr(32'hFC000000);
      check("T2 writes", nwe, 3);
      check("T2 addr0", log_addr[0], 0);
      check("T2 addr1", log_addr[1], 1);
      check("T2 addr2", log_addr[2], 2);
      check("T2 data0", log_data[0], 32'h11223344);
      check("T2 data1", log_data[1], 32'h55667788);
      check("T2 data2", log_data[2], 32'hFC000000);
      check("T2 state", state_out, 2);

      do_reset();
      send_byte(8'h01);
      for (int i = 1; i <= 4; i++) prog_instr(32'h11111111 * 32'(i));
      check("T3 writes", b_nwe, 4);
      check("T3 state", b_state, 2);
      for (int i = 0; i < 4; i++) check($sformatf("T3 addr%0d", i), 32'(b_addr[i]), i);
      prog_instr(32'h06010601);
      check("T3 extra writes", b_nwe, 4);
      check("T3 extra state", b_state, 2);

      do_reset();
      send_byte(8'h01);
      prog_instr(32'hFC000000);
      pc = 32'h00400020;
      pulse_cmd(8'h02);
      check("T4 run state", state_out, 4);
      check("T4 clk_en", mips_clk_en, 1);
      repeat (7) @(negedge clk);
      halt_in = 1'b1;
      #1 check("T4 clk_en at halt", mips_clk_en, 0);
      stream("T4", 32'h00400020, 32'd7, 3'd2);
      check("T4 enabled cycles", en_cnt, 7);
      halt_in = 1'b0;

      do_reset();
      send_byte(8'h01);
      prog_instr(32'hFC000000);
      send_byte(8'h07);
      prog_instr(32'h00000010);
      pc = 32'h0000000C;
      pulse_cmd(8'h08);
      pc = 32'h00000010;
      halt_in = 1'b1;
      #1 check("T5 clk_en at halt", mips_clk_en, 0);
      stream("T5", 32'h00000010, 32'd0, 3'd2);
      halt_in = 1'b0;
      pulse_cmd(8'h08);
      #1 check("T5b clk_en at bp", mips_clk_en, 0);
      stream("T5b", 32'h00000010, 32'd0, 3'd3);

      do_reset();
      send_byte(8'h01);
      prog_instr(32'hFC000000);
      pc = 32'h00400100;
      send_byte(8'h03);
      check("T6 step state", state_out, 3);
      pulse_cmd(8'h06);
      stream("T6a", 32'h00400100, 32'd1, 3'd3);
      check("T6a enabled cycles", en_cnt, 1);
      pulse_cmd(8'h06);
      stream("T6b", 32'h00400100, 32'd2, 3'd3);
      check("T6b enabled cycles", en_cnt, 2);

      pulse_cmd(8'h06);
      e0 = 0;
      for (int k = 0; k <= 10; k++) begin
         wait_tx(ok);
         if (!ok) e0++;
         if (k < 10) begin
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
         end
      end
      check("T1 handshake", e0, 0);
      check("T1 in send", state_out, 5);
      reset = 1'b1;
      @(negedge clk);
      check("T1 state", state_out, 0);
      check("T1 tx_start", tx_start, 0);
      check("T1 mips_reset", mips_reset, 1);
      check("T1 coll_restart", coll_restart, 0);
      reset = 1'b0;
      bad = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (coll_restart || tx_start) bad = 1'b1;
      end
      check("T1 quiet after reset", bad, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
